pinmux_switch_sequencer: RTL and testbench
==========================================

Name: pinmux_switch_sequencer

Overview:
Glitch-free output pin-mux controller for the board's output pin set. Each output pin chooses one of SRC_NUM driver sources (UART/SPI/GPIO/etc.). Software-side config writes arrive over a req/gnt port. Each source change is sequenced through a tri-stated blanking window, so two peripherals never drive the same pin mid-switch.

Parameters:
OUT_PIN_NUM, 19, number of output pins managed (matches board out-pin count)
SRC_NUM, 4, candidate sources per pin; source 0 is the reset default
HOLD_CYCLES, 4, blanking length in clk_i cycles (legal range 1..255)
PIN_W, $clog2(OUT_PIN_NUM), width of pin index
SEL_W, $clog2(SRC_NUM), width of source select

Ports:
clk_i  in  1  system clock; only clock
rst_i  in  1  asynchronous, active-high reset
cfg_req_i  in  1  config request; held high until cfg_gnt_o
cfg_pin_i  in  PIN_W  target output pin index
cfg_sel_i  in  SEL_W  requested source for target pin
cfg_gnt_o  out  1  one-cycle grant pulse; request retired
cfg_err_o  out  1  valid with cfg_gnt_o; request rejected, no state change
busy_o  out  1  sequencer not IDLE
src_out_i  in  SRC_NUM*OUT_PIN_NUM  source data, [s*OUT_PIN_NUM+p]
src_oe_i  in  SRC_NUM*OUT_PIN_NUM  source output enable, same packing
sel_o  out  SEL_W*OUT_PIN_NUM  current committed selection per pin (readback)
pin_out_o  out  OUT_PIN_NUM  registered pin data
pin_oe_o  out  OUT_PIN_NUM  registered pin output enable

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all sel = 0; blank mask = 0; state IDLE; counter 0; cfg_gnt_o, cfg_err_o, busy_o, pin_out_o, pin_oe_o all 0.
- Output path, per pin p, registered with 1-cycle latency:
  - If mask[p]: pin_out_o[p] <= 0 and pin_oe_o[p] <= 0.
  - Otherwise: pin_out_o[p] <= src_out_i[sel[p]*OUT_PIN_NUM+p] and pin_oe_o[p] likewise from src_oe_i.
- FSM states: IDLE, BLANK, COMMIT.
- IDLE, cfg_req_i sampled high at edge k:
  - cfg_pin_i >= OUT_PIN_NUM or cfg_sel_i >= SRC_NUM: pulse cfg_gnt_o=1 and cfg_err_o=1 in the cycle after edge k; stay IDLE; no change.
  - cfg_sel_i == sel[cfg_pin_i]: pulse cfg_gnt_o with cfg_err_o=0 after edge k; no blanking; stay IDLE.
  - Otherwise: latch pin and sel; mask[pin] <= 1; counter <= HOLD_CYCLES-1; go to BLANK.
- BLANK: counter decrements each cycle. At counter==0, go to COMMIT.
- COMMIT, a single cycle at edge k+HOLD_CYCLES:
  - sel[pin] <= latched sel; mask[pin] <= 0.
  - cfg_gnt_o pulses in the following cycle; go to IDLE.
- Blank window: pin_oe_o[pin] is 0 for exactly HOLD_CYCLES cycles (edges k+1..k+HOLD_CYCLES), then shows the new source at edge k+HOLD_CYCLES+1.
- busy_o = (state != IDLE), registered with the state.
- cfg_req_i is ignored while busy. The requester must deassert cfg_req_i in the cycle cfg_gnt_o is high; if it is still high, the next IDLE sample counts as a new request.
- Other pins are unaffected at all times.
- Only one switch is in flight at a time.
- Reset asserted mid-BLANK: immediate return to reset values. The pending switch is discarded with no grant; sel reverts to 0.
- Counter width is 8 bits; no wrap, since the load value is bounded by HOLD_CYCLES <= 255.

Optional Feature:
PINMUX_SWITCH_LOCK_EN
- Defined: adds input cfg_lock_i (1 bit).
  - A high sample in any state sets a sticky lock register; only rst_i clears it.
  - While locked, every new IDLE request returns cfg_gnt_o=1, cfg_err_o=1 with no state change.
  - A switch already in BLANK/COMMIT completes normally.
- Not defined: no cfg_lock_i port; no lock register.

Test Plan:
1. Reset release with src 0 driving pin 3 out=1/oe=1 -> pin_out_o[3]=1, pin_oe_o[3]=1 one cycle after the first edge; sel_o all 0.
2. Req pin=3, sel=2 at edge k (HOLD_CYCLES=4), src2 out=0/oe=1:
   - pin_oe_o[3]=0 for exactly 4 cycles;
   - cfg_gnt_o pulses once, 1 cycle after edge k+4, with err=0;
   - sel_o[3]=2; pin_oe_o[3]=1 at edge k+5.
3. Req pin=19 or sel=... with SRC_NUM=3 config sel=3 -> gnt=1, err=1 one cycle after accept; busy_o stays 0; outputs unchanged.
4. Req pin=5 with sel equal to current -> gnt after 1 cycle, err=0, no blank cycle on pin_oe_o[5].
5. Second request asserted while busy -> not granted until the first completes; it is then processed, total grants = 2. Assert rst_i mid-BLANK -> all outputs 0, sel_o 0, no grant.
6. With PINMUX_SWITCH_LOCK_EN: pulse cfg_lock_i, then request pin=1 sel=1 -> gnt=1, err=1, sel_o unchanged until rst_i.

Source files
------------

// File: rtl/pinmux_switch_sequencer.sv
// Glitch-free output pin-mux: every source change tri-states the pin for HOLD_CYCLES before it commits.
// Build macro PINMUX_SWITCH_LOCK_EN adds a sticky cfg_lock_i that rejects all later config requests.
module pinmux_switch_sequencer #(
  parameter int unsigned OUT_PIN_NUM = 19,
  parameter int unsigned SRC_NUM     = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned PIN_W       = $clog2(OUT_PIN_NUM),
  parameter int unsigned SEL_W       = $clog2(SRC_NUM)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_req_i,
  input  logic [PIN_W-1:0]               cfg_pin_i,
  input  logic [SEL_W-1:0]               cfg_sel_i,
`ifdef PINMUX_SWITCH_LOCK_EN
  input  logic                           cfg_lock_i,
`endif
  output logic                           cfg_gnt_o,
  output logic                           cfg_err_o,
  output logic                           busy_o,
  input  logic [SRC_NUM*OUT_PIN_NUM-1:0] src_out_i,
  input  logic [SRC_NUM*OUT_PIN_NUM-1:0] src_oe_i,
  output logic [SEL_W*OUT_PIN_NUM-1:0]   sel_o,
  output logic [OUT_PIN_NUM-1:0]         pin_out_o,
  output logic [OUT_PIN_NUM-1:0]         pin_oe_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PIN_W-1:0]       pin_q;
  logic [SEL_W-1:0]       new_sel_q;
  logic [SEL_W-1:0]       sel_q [OUT_PIN_NUM];
  logic [OUT_PIN_NUM-1:0] mask_q;

  logic                   locked_c;
  logic                   req_bad_c;
  logic                   req_same_c;
  logic [SEL_W-1:0]       cur_sel_c;
  logic [OUT_PIN_NUM-1:0] mux_out_c;
  logic [OUT_PIN_NUM-1:0] mux_oe_c;

`ifdef PINMUX_SWITCH_LOCK_EN
  logic lock_q;

  // Sticky lock: once sampled high, only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
    end else if (cfg_lock_i) begin
      lock_q <= 1'b1;
    end
  end

  assign locked_c = lock_q;
`else
  assign locked_c = 1'b0;
`endif

  // Current selection of the requested pin (0 for out-of-range pins, which are rejected anyway).
  always_comb begin
    cur_sel_c = '0;
    for (int p = 0; p < int'(OUT_PIN_NUM); p++) begin
      if (cfg_pin_i == PIN_W'(p)) begin
        cur_sel_c = sel_q[p];
      end
    end
  end

  assign req_bad_c  = (32'(cfg_pin_i) >= OUT_PIN_NUM) || (32'(cfg_sel_i) >= SRC_NUM) || locked_c;
  assign req_same_c = (cfg_sel_i == cur_sel_c);

  // Per-pin source mux ahead of the output register.
  always_comb begin
    mux_out_c = '0;
    mux_oe_c  = '0;
    for (int p = 0; p < int'(OUT_PIN_NUM); p++) begin
      for (int s = 0; s < int'(SRC_NUM); s++) begin
        if (sel_q[p] == SEL_W'(s)) begin
          mux_out_c[p] = src_out_i[s*int'(OUT_PIN_NUM)+p];
          mux_oe_c[p]  = src_oe_i[s*int'(OUT_PIN_NUM)+p];
        end
      end
    end
  end

  for (genvar g = 0; g < int'(OUT_PIN_NUM); g++) begin : g_sel
    assign sel_o[g*SEL_W +: SEL_W] = sel_q[g];
  end

  // Sequencer FSM with registered pins, grant/error pulses and busy flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pin_q     <= '0;
      new_sel_q <= '0;
      mask_q    <= '0;
      for (int p = 0; p < int'(OUT_PIN_NUM); p++) begin
        sel_q[p] <= '0;
      end
      cfg_gnt_o <= 1'b0;
      cfg_err_o <= 1'b0;
      busy_o    <= 1'b0;
      pin_out_o <= '0;
      pin_oe_o  <= '0;
    end else begin
      cfg_gnt_o <= 1'b0;
      cfg_err_o <= 1'b0;
      pin_out_o <= mux_out_c & ~mask_q;
      pin_oe_o  <= mux_oe_c & ~mask_q;
      case (state_q)
        IDLE: begin
          if (cfg_req_i) begin
            if (req_bad_c) begin
              cfg_gnt_o <= 1'b1;
              cfg_err_o <= 1'b1;
            end else if (req_same_c) begin
              cfg_gnt_o <= 1'b1;
            end else begin
              pin_q             <= cfg_pin_i;
              new_sel_q         <= cfg_sel_i;
              mask_q[cfg_pin_i] <= 1'b1;
              cnt_q             <= CNT_W'(HOLD_CYCLES - 1);
              state_q           <= BLANK;
              busy_o            <= 1'b1;
            end
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            sel_q[pin_q]  <= new_sel_q;
            mask_q[pin_q] <= 1'b0;
            state_q       <= COMMIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        COMMIT: begin
          cfg_gnt_o <= 1'b1;
          state_q   <= IDLE;
          busy_o    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pinmux_switch_sequencer.sv
// Randomised and directed bench for pinmux_switch_sequencer against a timeline reference model.
// Define PINMUX_SWITCH_LOCK_EN for both files to also exercise the lock feature.
module tb_pinmux_switch_sequencer;

  localparam int unsigned N  = 19;
  localparam int unsigned S  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 5;
  localparam int unsigned SW = 2;
  localparam int unsigned VW = 3 + SW*N + 2*N;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_req;
  logic [PW-1:0]    cfg_pin;
  logic [SW-1:0]    cfg_sel;
  logic             cfg_lock;
  logic             cfg_gnt;
  logic             cfg_err;
  logic             busy;
  logic [S*N-1:0]   src_out;
  logic [S*N-1:0]   src_oe;
  logic [SW*N-1:0]  sel_o;
  logic [N-1:0]     pin_out;
  logic [N-1:0]     pin_oe;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: committed selections plus the timeline of the one switch in flight.
  int  m_sel [N];
  bit  m_active;
  int  m_k, m_pin, m_new;
  bit  m_lock;
  logic            e_gnt, e_err, e_busy;
  logic [N-1:0]    e_out, e_oe;
  logic [SW*N-1:0] e_sel;

  always #5 clk = ~clk;

  pinmux_switch_sequencer #(
    .OUT_PIN_NUM(N), .SRC_NUM(S), .HOLD_CYCLES(H), .PIN_W(PW), .SEL_W(SW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cfg_req_i (cfg_req),
    .cfg_pin_i (cfg_pin),
    .cfg_sel_i (cfg_sel),
`ifdef PINMUX_SWITCH_LOCK_EN
    .cfg_lock_i(cfg_lock),
`endif
    .cfg_gnt_o (cfg_gnt),
    .cfg_err_o (cfg_err),
    .busy_o    (busy),
    .src_out_i (src_out),
    .src_oe_i  (src_oe),
    .sel_o     (sel_o),
    .pin_out_o (pin_out),
    .pin_oe_o  (pin_oe)
  );

  function automatic logic [VW-1:0] act_vec();
    return {cfg_gnt, cfg_err, busy, sel_o, pin_out, pin_oe};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_gnt, e_err, e_busy, e_sel, e_out, e_oe};
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_active = 1'b0;
    m_lock = 1'b0;
    m_k = 0; m_pin = 0; m_new = 0;
    for (int p = 0; p < N; p++) m_sel[p] = 0;
    e_gnt = 0; e_err = 0; e_busy = 0;
    e_out = '0; e_oe = '0; e_sel = '0;
  endtask

  // One clock edge: pin k accepted at edge m_k is blank on edges m_k+1..m_k+H,
  // its selection commits at edge m_k+H, and the grant follows at edge m_k+H+1.
  task automatic model_edge();
    int n;
    bit blank;
    cyc++;
    n = cyc;
    for (int p = 0; p < N; p++) begin
      blank = m_active && (p == m_pin) && (n >= m_k + 1) && (n <= m_k + int'(H));
      e_out[p] = blank ? 1'b0 : src_out[m_sel[p]*N + p];
      e_oe[p]  = blank ? 1'b0 : src_oe[m_sel[p]*N + p];
    end
    e_gnt = 1'b0;
    e_err = 1'b0;
    if (m_active) begin
      if (n == m_k + int'(H)) m_sel[m_pin] = m_new;
      if (n == m_k + int'(H) + 1) begin
        e_gnt = 1'b1;
        m_active = 1'b0;
      end
    end else if (cfg_req === 1'b1) begin
      if (int'(cfg_pin) >= int'(N) || int'(cfg_sel) >= int'(S) || m_lock) begin
        e_gnt = 1'b1;
        e_err = 1'b1;
      end else if (int'(cfg_sel) == m_sel[cfg_pin]) begin
        e_gnt = 1'b1;
      end else begin
        m_active = 1'b1;
        m_k = n;
        m_pin = int'(cfg_pin);
        m_new = int'(cfg_sel);
      end
    end
`ifdef PINMUX_SWITCH_LOCK_EN
    if (cfg_lock === 1'b1) m_lock = 1'b1;
`endif
    e_busy = m_active;
    for (int p = 0; p < N; p++) e_sel[p*SW +: SW] = SW'(m_sel[p]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_out = '0;
    src_oe = '0;
    src_out[0*N + 3] = 1'b1;
    src_oe[0*N + 3] = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h exp 0", act_vec());
    end
    rst = 1'b0;
    model_reset();
    step();
    vectors++;
    if (pin_out[3] !== 1'b1 || pin_oe[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pin3: got out=%b oe=%b exp out=1 oe=1", pin_out[3], pin_oe[3]);
    end
    vectors++;
    if (sel_o !== '0 || busy !== 1'b0 || cfg_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got sel=%h busy=%b gnt=%b exp 0", sel_o, busy, cfg_gnt);
    end
  endtask

  task automatic test_switch();
    int zeros, gnts;
    src_out = (S*N)'({$urandom(), $urandom(), $urandom()});
    src_oe = '1;
    src_out[2*N + 3] = 1'b0;
    cfg_req = 1'b1; cfg_pin = PW'(3); cfg_sel = SW'(2);
    step();
    vectors++;
    if (busy !== 1'b1 || cfg_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_accept: got busy=%b gnt=%b exp busy=1 gnt=0", busy, cfg_gnt);
    end
    zeros = 0;
    gnts = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (pin_oe[3] === 1'b0) zeros++;
      if (cfg_gnt === 1'b1) begin
        gnts++;
        vectors++;
        if (cfg_err !== 1'b0 || i != int'(H)) begin
          miscompares++;
          $display("FAIL sw_gnt_timing: got err=%b at edge k+%0d exp err=0 at edge k+%0d", cfg_err, i + 1, H + 1);
        end
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sw_cycle %0d: got %h exp %h", i, act_vec(), exp_vec());
      end
      if (e_gnt) cfg_req = 1'b0;
    end
    vectors++;
    if (zeros != int'(H) || gnts != 1) begin
      miscompares++;
      $display("FAIL sw_window: got blank=%0d grants=%0d exp blank=%0d grants=1", zeros, gnts, H);
    end
    vectors++;
    if (sel_o[3*SW +: SW] !== SW'(2) || pin_oe[3] !== 1'b1 || pin_out[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_final: got sel=%0d oe=%b out=%b exp sel=2 oe=1 out=0",
               sel_o[3*SW +: SW], pin_oe[3], pin_out[3]);
    end
  endtask

  task automatic test_errors();
    int bad_pins [2];
    bad_pins = '{19, 31};
    for (int j = 0; j < 2; j++) begin
      cfg_req = 1'b1; cfg_pin = PW'(bad_pins[j]); cfg_sel = SW'(1);
      step();
      vectors++;
      if ({cfg_gnt, cfg_err, busy} !== 3'b110) begin
        miscompares++;
        $display("FAIL err_pin%0d: got gnt/err/busy=%b exp 110", bad_pins[j], {cfg_gnt, cfg_err, busy});
      end
      cfg_req = 1'b0;
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL err_after%0d: got %h exp %h", bad_pins[j], act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_same_sel();
    cfg_req = 1'b1; cfg_pin = PW'(5); cfg_sel = SW'(m_sel[5]);
    step();
    vectors++;
    if ({cfg_gnt, cfg_err, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL same_gnt: got gnt/err/busy=%b exp 100", {cfg_gnt, cfg_err, busy});
    end
    cfg_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (pin_oe[5] !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL same_noblank %0d: got oe=%b busy=%b exp oe=1 busy=0", i, pin_oe[5], busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gnts, mg;
    logic [SW-1:0] sel7, sel8;
    sel7 = SW'((m_sel[7] + 1) % S);
    sel8 = SW'((m_sel[8] + 3) % S);
    cfg_req = 1'b1; cfg_pin = PW'(7); cfg_sel = sel7;
    step();
    cfg_pin = PW'(8); cfg_sel = sel8;
    gnts = 0;
    mg = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cfg_gnt === 1'b1) gnts++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_cycle %0d: got %h exp %h", i, act_vec(), exp_vec());
      end
      if (e_gnt) mg++;
      if (mg == 2) cfg_req = 1'b0;
    end
    vectors++;
    if (gnts != 2 || sel_o[7*SW +: SW] !== sel7 || sel_o[8*SW +: SW] !== sel8) begin
      miscompares++;
      $display("FAIL b2b_result: got grants=%0d sel7=%0d sel8=%0d exp grants=2 sel7=%0d sel8=%0d",
               gnts, sel_o[7*SW +: SW], sel_o[8*SW +: SW], sel7, sel8);
    end
  endtask

  task automatic test_reset_mid_blank();
    int gnts;
    cfg_req = 1'b1; cfg_pin = PW'(2); cfg_sel = SW'((m_sel[2] + 3) % S);
    step();
    step();
    step();
    rst = 1'b1;
    cfg_req = 1'b0;
    #1;
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++;
      $display("FAIL rstblank_async: got %h exp 0", act_vec());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    gnts = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cfg_gnt === 1'b1) gnts++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rstblank_cycle %0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (gnts != 0 || sel_o !== '0) begin
      miscompares++;
      $display("FAIL rstblank_result: got grants=%0d sel=%h exp grants=0 sel=0", gnts, sel_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      src_out = (S*N)'({$urandom(), $urandom(), $urandom()});
      src_oe = (S*N)'({$urandom(), $urandom(), $urandom()});
      if (cfg_req == 1'b0 && $urandom_range(0, 2) == 0) begin
        cfg_req = 1'b1;
        cfg_pin = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(19, 31)) : PW'($urandom_range(0, 18));
        cfg_sel = SW'($urandom_range(0, 3));
      end
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rnd_cycle %0d: got %h exp %h", i, act_vec(), exp_vec());
      end
      if (e_gnt) cfg_req = 1'b0;
    end
    cfg_req = 1'b0;
    for (int i = 0; i < int'(H) + 3; i++) step();
  endtask

`ifdef PINMUX_SWITCH_LOCK_EN
  task automatic test_lock();
    logic [SW*N-1:0] sel_before;
    bit done;
    src_oe = '1;
    cfg_lock = 1'b1;
    step();
    cfg_lock = 1'b0;
    sel_before = sel_o;
    cfg_req = 1'b1; cfg_pin = PW'(1); cfg_sel = SW'((m_sel[1] + 1) % S);
    step();
    vectors++;
    if ({cfg_gnt, cfg_err, busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL lock_reject: got gnt/err/busy=%b exp 110", {cfg_gnt, cfg_err, busy});
    end
    cfg_req = 1'b0;
    step();
    vectors++;
    if (sel_o !== sel_before) begin
      miscompares++;
      $display("FAIL lock_sel: got %h exp %h", sel_o, sel_before);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cfg_req = 1'b1; cfg_pin = PW'(1); cfg_sel = SW'(1);
    step();
    vectors++;
    if (busy !== 1'b1 || cfg_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_cleared: got busy=%b gnt=%b exp busy=1 gnt=0", busy, cfg_gnt);
    end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (e_gnt) begin
        cfg_req = 1'b0;
        done = 1'b1;
      end
    end
    vectors++;
    if (!done || cfg_gnt !== 1'b1 || cfg_err !== 1'b0 || sel_o[1*SW +: SW] !== SW'(1)) begin
      miscompares++;
      $display("FAIL lock_after_reset: got gnt=%b err=%b sel1=%0d exp gnt=1 err=0 sel1=1",
               cfg_gnt, cfg_err, sel_o[1*SW +: SW]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_req = 1'b0;
    cfg_pin = '0;
    cfg_sel = '0;
    cfg_lock = 1'b0;
    src_out = '0;
    src_oe = '0;
    model_reset();
    test_reset();
    test_switch();
    test_errors();
    test_same_sel();
    test_back_to_back();
    test_reset_mid_blank();
    test_random();
`ifdef PINMUX_SWITCH_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
